// File: rtl/gpio_ctrl.sv
// gpio_ctrl: memory-mapped GPIO block on the CPU data bus. It has per-pin
// direction control, output toggling, synchronised inputs, sticky edge
// status, and one level interrupt. Read data is registered, so it has
// one cycle of latency, the same as the data RAM.
module gpio_ctrl #(
  parameter int          WIDTH     = 8,
  parameter logic [31:0] BASE_ADDR = 32'h0000_0400
) (
  input  logic             clk,
  input  logic             rstn,
  input  logic [31:0]      data_addr,
  input  logic             datamem_rd,
  input  logic             datamem_wr,
  input  logic [31:0]      data_wr,
  output logic [31:0]      data_rd,
  input  logic [WIDTH-1:0] gpio_i,
  output logic [WIDTH-1:0] gpio_o,
  output logic [WIDTH-1:0] gpio_oe,
  output logic             irq
);

  localparam logic [2:0] REG_DATA_OUT = 3'd0;
  localparam logic [2:0] REG_DIR      = 3'd1;
  localparam logic [2:0] REG_DATA_IN  = 3'd2;
  localparam logic [2:0] REG_IRQ_EN   = 3'd3;
  localparam logic [2:0] REG_RISE_EN  = 3'd4;
  localparam logic [2:0] REG_FALL_EN  = 3'd5;
  localparam logic [2:0] REG_STATUS   = 3'd6;
  localparam logic [2:0] REG_TOGGLE   = 3'd7;

  logic [WIDTH-1:0] data_out, dir, irq_en, rise_en, fall_en, irq_status;
  logic [WIDTH-1:0] s1, s2, prev;
  logic [WIDTH-1:0] wdata, rise, fall, status_set, status_clr;
  logic [2:0]       sel;
  logic             hit, wr, rd;
  logic [31:0]      rd_word;
  logic             unused_bits;

  // Byte lanes and the upper write-data bits beyond WIDTH are ignored by design.
  assign unused_bits = ^{data_addr[1:0], data_wr};

  assign hit   = (data_addr[31:5] == BASE_ADDR[31:5]);
  assign sel   = data_addr[4:2];
  assign wr    = datamem_wr & hit;
  assign rd    = datamem_rd & hit;
  assign wdata = data_wr[WIDTH-1:0];

  assign rise       = s2 & ~prev;
  assign fall       = ~s2 & prev;
  assign status_set = (rise & rise_en) | (fall & fall_en);
  assign status_clr = (wr && sel == REG_STATUS) ? wdata : '0;

  assign gpio_o  = data_out;
  assign gpio_oe = dir;
  assign irq     = |(irq_status & irq_en);

  // Two-flop synchroniser for the asynchronous pins. The prev flop is used for edge detection.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      s1   <= '0;
      s2   <= '0;
      prev <= '0;
    end else begin
      s1   <= gpio_i;
      s2   <= s1;
      prev <= s2;
    end
  end

  // Control register writes. If a hardware edge and a W1C hit the same status bit in one cycle, the edge wins.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      data_out   <= '0;
      dir        <= '0;
      irq_en     <= '0;
      rise_en    <= '0;
      fall_en    <= '0;
      irq_status <= '0;
    end else begin
      irq_status <= (irq_status & ~status_clr) | status_set;
      if (wr) begin
        case (sel)
          REG_DATA_OUT: data_out <= wdata;
          REG_DIR:      dir      <= wdata;
          REG_IRQ_EN:   irq_en   <= wdata;
          REG_RISE_EN:  rise_en  <= wdata;
          REG_FALL_EN:  fall_en  <= wdata;
          REG_TOGGLE:   data_out <= data_out ^ wdata;
          default: ;
        endcase
      end
    end
  end

  // Read mux. The value is zero-extended to the bus width. TOGGLE and unmapped cases read as zero.
  always_comb begin
    rd_word = '0;
    case (sel)
      REG_DATA_OUT: rd_word[WIDTH-1:0] = data_out;
      REG_DIR:      rd_word[WIDTH-1:0] = dir;
      REG_DATA_IN:  rd_word[WIDTH-1:0] = s2;
      REG_IRQ_EN:   rd_word[WIDTH-1:0] = irq_en;
      REG_RISE_EN:  rd_word[WIDTH-1:0] = rise_en;
      REG_FALL_EN:  rd_word[WIDTH-1:0] = fall_en;
      REG_STATUS:   rd_word[WIDTH-1:0] = irq_status;
      default:      rd_word = '0;
    endcase
  end

  // Registered read data. It holds for the single cycle after a read strobe and is zero at all other times.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) data_rd <= '0;
    else       data_rd <= rd ? rd_word : 32'h0;
  end

endmodule

// File: tb/tb_gpio_ctrl.sv
// Directed self-checking bench for gpio_ctrl with WIDTH = 8 and base address 0x400.
module tb_gpio_ctrl;

  logic        clk = 1'b0;
  logic        rstn = 1'b0;
  logic [31:0] data_addr = '0;
  logic        datamem_rd = 1'b0;
  logic        datamem_wr = 1'b0;
  logic [31:0] data_wr = '0;
  logic [31:0] data_rd;
  logic [7:0]  gpio_i = '0;
  logic [7:0]  gpio_o;
  logic [7:0]  gpio_oe;
  logic        irq;

  int total = 0;
  int bad   = 0;
  logic [31:0] rv;

  gpio_ctrl #(.WIDTH(8), .BASE_ADDR(32'h0000_0400)) dut (
    .clk(clk), .rstn(rstn), .data_addr(data_addr), .datamem_rd(datamem_rd),
    .datamem_wr(datamem_wr), .data_wr(data_wr), .data_rd(data_rd),
    .gpio_i(gpio_i), .gpio_o(gpio_o), .gpio_oe(gpio_oe), .irq(irq)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic bus_write(input logic [31:0] addr, input logic [31:0] d);
    @(negedge clk);
    data_addr = addr; data_wr = d; datamem_wr = 1'b1;
    @(negedge clk);
    datamem_wr = 1'b0;
  endtask

  task automatic bus_read(input logic [31:0] addr, output logic [31:0] d);
    @(negedge clk);
    data_addr = addr; datamem_rd = 1'b1;
    @(negedge clk);
    datamem_rd = 1'b0;
    d = data_rd;
  endtask

  initial begin
    // Reset held with all pins high
    gpio_i = 8'hFF;
    repeat (3) @(negedge clk);
    check("rst_gpio_o", 32'(gpio_o), 32'h0);
    check("rst_gpio_oe", 32'(gpio_oe), 32'h0);
    check("rst_irq", 32'(irq), 32'h0);
    check("rst_data_rd", data_rd, 32'h0);
    rstn = 1'b1;
    repeat (4) @(negedge clk);
    bus_read(32'h418, rv);
    check("rst_status", rv, 32'h0);

    // Output path
    bus_write(32'h400, 32'h5A);
    bus_write(32'h404, 32'h0F);
    bus_write(32'h41C, 32'hFF);
    check("out_gpio_o", 32'(gpio_o), 32'hA5);
    check("out_gpio_oe", 32'(gpio_oe), 32'h0F);
    bus_read(32'h400, rv);
    check("rd_data_out", rv, 32'h0000_00A5);
    @(negedge clk);
    check("rd_one_cycle", data_rd, 32'h0);
    bus_read(32'h404, rv);
    check("rd_dir", rv, 32'h0F);

    // Read and write in the same cycle: the read returns the pre-write value
    @(negedge clk);
    data_addr = 32'h400; data_wr = 32'h11; datamem_wr = 1'b1; datamem_rd = 1'b1;
    @(negedge clk);
    datamem_wr = 1'b0; datamem_rd = 1'b0;
    check("rw_old_value", data_rd, 32'hA5);
    check("rw_gpio_o", 32'(gpio_o), 32'h11);
    bus_write(32'h400, 32'hA5);

    // Input synchroniser latency
    @(negedge clk);
    gpio_i = 8'h3C;
    @(negedge clk);
    data_addr = 32'h408; datamem_rd = 1'b1;
    @(negedge clk);
    check("sync_old", data_rd, 32'hFF);
    @(negedge clk);
    datamem_rd = 1'b0;
    check("sync_new", data_rd, 32'h3C);
    bus_write(32'h408, 32'h00);
    bus_read(32'h408, rv);
    check("data_in_ro", rv, 32'h3C);

    // Edge interrupt. Pin 7 is raised first while all enables are still off.
    gpio_i = 8'hBC;
    repeat (4) @(negedge clk);
    bus_write(32'h410, 32'h01);
    bus_write(32'h414, 32'h80);
    bus_write(32'h40C, 32'hFFFF_FF81);
    bus_read(32'h40C, rv);
    check("irq_en_upper_ignored", rv, 32'h81);
    bus_read(32'h418, rv);
    check("status_quiet", rv, 32'h0);
    check("irq_quiet", 32'(irq), 32'h0);
    @(negedge clk);
    gpio_i = 8'h3D;
    @(negedge clk);
    @(negedge clk);
    check("irq_before_e2", 32'(irq), 32'h0);
    @(negedge clk);
    check("irq_after_e2", 32'(irq), 32'h1);
    bus_read(32'h418, rv);
    check("status_81", rv, 32'h81);
    bus_write(32'h418, 32'h01);
    check("irq_still_set", 32'(irq), 32'h1);
    bus_read(32'h418, rv);
    check("status_80", rv, 32'h80);
    bus_write(32'h418, 32'h80);
    check("irq_cleared", 32'(irq), 32'h0);

    // Collision: a hardware set and a W1C of bit 0 in the same cycle
    gpio_i = 8'h3C;
    repeat (4) @(negedge clk);
    bus_read(32'h418, rv);
    check("fall_not_enabled", rv, 32'h0);
    gpio_i = 8'h3D;
    @(negedge clk);
    @(negedge clk);
    data_addr = 32'h418; data_wr = 32'h01; datamem_wr = 1'b1;
    @(negedge clk);
    datamem_wr = 1'b0;
    check("collide_irq", 32'(irq), 32'h1);
    bus_read(32'h418, rv);
    check("collide_status", rv, 32'h01);

    // Address decode
    bus_write(32'h000, 32'hFF);
    bus_write(32'h420, 32'hFF);
    check("decode_gpio_o", 32'(gpio_o), 32'hA5);
    bus_read(32'h420, rv);
    check("decode_rd_miss", rv, 32'h0);
    bus_read(32'h41C, rv);
    check("toggle_reads_0", rv, 32'h0);

    // Asynchronous reset with an interrupt pending
    check("pre_areset_irq", 32'(irq), 32'h1);
    @(negedge clk);
    #2 rstn = 1'b0;
    #1;
    check("areset_irq", 32'(irq), 32'h0);
    check("areset_gpio_o", 32'(gpio_o), 32'h0);
    check("areset_gpio_oe", 32'(gpio_oe), 32'h0);
    @(negedge clk);
    rstn = 1'b1;
    bus_read(32'h418, rv);
    check("areset_status", rv, 32'h0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/gpio_ctrl.md
# gpio_ctrl

Memory-mapped, parametrised GPIO controller on the CPU data bus, replacing the single write-only 8-bit output latch in the FPGA top. It decodes its own 32-byte window and provides per-pin direction control and output toggling. Inputs are synchronised and readable, with edge-detect interrupt status and a single level interrupt to the core. Read data is registered, matching the one-cycle latency of the data RAM.

## Interface
- WIDTH, 8, number of GPIO pins (1..32)
- BASE_ADDR, 32'h0000_0400, byte base of the register window; must be 32-byte aligned
- clk  in  1  system clock, all logic on rising edge
- rstn  in  1  reset, asynchronous, active-low
- data_addr  in  32  CPU byte address
- datamem_rd  in  1  read strobe, single cycle
- datamem_wr  in  1  write strobe, single cycle
- data_wr  in  32  write data
- data_rd  out  32  read data, registered
- gpio_i  in  WIDTH  asynchronous pin inputs
- gpio_o  out  WIDTH  output data (DATA_OUT register)
- gpio_oe  out  WIDTH  output enable per pin (DIR register), 1 = drive
- irq  out  1  level interrupt, high while any enabled status bit is set

## Operation
- Hit: data_addr[31:5] == BASE_ADDR[31:5]. Register selected by data_addr[4:2]; data_addr[1:0] ignored. No hit: no write, data_rd <= 0.
- Register map (byte offset):
  - 0x00 DATA_OUT, RW
  - 0x04 DIR, RW
  - 0x08 DATA_IN, RO; synchronised pins, irrespective of DIR
  - 0x0C IRQ_EN, RW
  - 0x10 RISE_EN, RW
  - 0x14 FALL_EN, RW
  - 0x18 IRQ_STATUS, RW1C
  - 0x1C TOGGLE, WO; DATA_OUT <= DATA_OUT ^ data_wr; reads 0
- Writes use data_wr[WIDTH-1:0]; upper bits are ignored. Reads are zero-extended to 32 bits. Writes to DATA_IN have no effect.
- Input path: 2-flop synchroniser (s1, s2), plus a prev flop holding the last s2.
  - rise = s2 & ~prev; fall = ~s2 & prev
- Status set: IRQ_STATUS[i] sets on (rise[i] & RISE_EN[i]) | (fall[i] & FALL_EN[i]). Setting does not depend on IRQ_EN. Bits are sticky until cleared by writing 1.
- irq = |(IRQ_STATUS & IRQ_EN), combinational from registers.
- All registers, synchroniser and prev flops reset to 0. Outputs at reset: gpio_o=0, gpio_oe=0, irq=0, data_rd=0.

## Timing
- Write: register updates at the clk edge where datamem_wr & hit. gpio_o/gpio_oe change right after that edge.
- Read: data_rd is valid for one cycle, in the cycle after the datamem_rd & hit strobe. It returns 0 in all other cycles.
- Read and write in the same cycle: the write takes effect and data_rd returns the pre-write value.
- Input latency: gpio_i stable before edge E0 -> s2 updates at E1. DATA_IN reflects the new value from a read strobed in the cycle after E1. Status bit sets at E2; irq high after E2.
- Pulses shorter than one clk period may be missed. No debounce is provided.
- Hardware set and W1C of the same bit in the same cycle: set wins, and the bit stays 1.
- Rise/fall enables written while the pin is changing: the edge is evaluated against enables as of the edge cycle.
- Pins high at reset release produce a rise in s2/prev. This is not recorded, because RISE_EN=0 after reset.
- Asynchronous reset mid-operation clears all state immediately. Pending status is lost and irq drops without waiting for a clock.

## Test plan
- Reset: hold rstn=0 with gpio_i=8'hFF -> gpio_o=0, gpio_oe=0, irq=0, data_rd=0. After release, IRQ_STATUS reads 0.
- Output path: write 0x5A to 0x400, write 0x0F to 0x404, write 0xFF to 0x41C -> gpio_o=0xA5, gpio_oe=0x0F. Readback of 0x400 gives 0x000000A5 one cycle after the strobe.
- Input sync: drive gpio_i=0x3C before edge E0 -> a read of 0x408 strobed after E1 returns 0x3C; a read strobed at E1 returns the old value.
- Edge interrupt: RISE_EN=0x01, FALL_EN=0x80, IRQ_EN=0x81. Toggle pin 0 up and pin 7 down -> IRQ_STATUS=0x81 at E2 and irq=1. Write 0x01 to 0x418 -> status 0x80, irq stays 1. Write 0x80 -> irq=0.
- Collision: write 1 to IRQ_STATUS[0] in the same cycle a rising edge on pin 0 sets it -> bit remains 1 and irq stays high.
- Decode: write 0xFF to 0x000 and to 0x420 -> gpio_o unchanged. A read of 0x420 returns 0; a read of 0x41C returns 0.
